// File: rtl/scr1_rst_seq_if.sv
// scr1_rst_seq_if: per-domain reset requests, DFT controls and sequencer status
interface scr1_rst_seq_if #(
  parameter int DOM_NUM = 3
);
  logic [DOM_NUM-1:0] dom_rst_req_i;
  logic               test_mode;
  logic               test_rst_n;
  logic [DOM_NUM-1:0] dom_rst_n_o;
  logic [DOM_NUM-1:0] dom_rdc_qlfy_o;
  logic               all_rel_o;
  modport master (
    output dom_rst_req_i, test_mode, test_rst_n,
    input  dom_rst_n_o, dom_rdc_qlfy_o, all_rel_o
  );
  modport slave (
    input  dom_rst_req_i, test_mode, test_rst_n,
    output dom_rst_n_o, dom_rdc_qlfy_o, all_rel_o
  );
endinterface

// File: rtl/scr1_rst_seq.sv
// scr1_rst_seq: multi-domain reset sequencer with ordered, gapped release and RDC qualifiers
module scr1_rst_seq #(
  parameter int DOM_NUM     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input logic           clk,
  input logic           rst,
  scr1_rst_seq_if.slave bus
);
  localparam int CNT_MAX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_C  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] GAP_M1 = CW'(GAP_CYCLES - 1);
  logic [DOM_NUM-1:0] sync [SYNC_STAGES];
  logic [DOM_NUM-1:0] req_s, eff, run, run_nxt, qlfy;
  logic [CW-1:0]      cnt     [DOM_NUM];
  logic [CW-1:0]      cnt_nxt [DOM_NUM];
  logic               chain;
  logic               gap_ok;
  always_ff @(posedge clk) begin
    sync[0] <= rst ? '1 : bus.dom_rst_req_i;
    for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= rst ? '1 : sync[s-1];
  end
  assign req_s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= '0;
      qlfy <= '0;
      for (int i = 0; i < DOM_NUM; i++) cnt[i] <= '0;
    end else begin
      run  <= run_nxt;
      qlfy <= run & run_nxt;
      for (int i = 0; i < DOM_NUM; i++) cnt[i] <= cnt_nxt[i];
    end
  end
  // gap_ok uses GAP-1 because the outer domain's release edge itself counts as its first RUN cycle
  always_comb begin
    chain  = rst;
    gap_ok = 1'b1;
    for (int i = 0; i < DOM_NUM; i++) begin
      chain      = chain | req_s[i];
      eff[i]     = chain;
      run_nxt[i] = !eff[i] && (run[i] || (cnt[i] >= HOLD_C && gap_ok));
      cnt_nxt[i] = (eff[i] || run_nxt[i] != run[i]) ? '0 :
                   (cnt[i] >= (run[i] ? GAP_C : HOLD_C)) ? cnt[i] : cnt[i] + 1'b1;
      gap_ok     = run[i] && cnt[i] >= GAP_M1;
    end
  end
  always_comb begin
    bus.dom_rst_n_o    = bus.test_mode ? {DOM_NUM{bus.test_rst_n}} : run;
    bus.dom_rdc_qlfy_o = qlfy;
    bus.all_rel_o      = &qlfy;
  end
endmodule

// File: tb/tb_scr1_rst_seq.sv
// tb_scr1_rst_seq: timestamp-based reference model plus directed timeline checks for scr1_rst_seq
module tb_scr1_rst_seq;
  localparam int N = 3, S = 2, H = 4, G = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  scr1_rst_seq_if #(.DOM_NUM(N)) bus ();
  scr1_rst_seq_if #(.DOM_NUM(1)) sbus ();
  scr1_rst_seq #(.DOM_NUM(N), .SYNC_STAGES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  scr1_rst_seq #(.DOM_NUM(1), .SYNC_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) sdut (
    .clk(clk), .rst(rst), .bus(sbus)
  );
  int errs = 0, checks = 0;
  int n = 0;
  int last_eff [N];
  int up_since [N];
  bit [N-1:0] up = '0;
  bit [N-1:0] sq [$];
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // a domain rises once eff has been quiet for more than H edges and its parent has been up G edges
  task automatic step();
    bit [N-1:0] rs, nu;
    bit e;
    n++;
    rs = sq[0];
    e  = rst;
    nu = up;
    for (int i = 0; i < N; i++) begin
      e = e | rs[i];
      if (e) begin
        nu[i] = 1'b0;
        last_eff[i] = n;
      end else if (!up[i] && n - last_eff[i] > H && (i == 0 || (up[i-1] && n - up_since[i-1] >= G))) begin
        nu[i] = 1'b1;
        up_since[i] = n;
      end
    end
    up = nu;
    if (rst) begin
      sq.delete();
      repeat (S) sq.push_back('1);
    end else begin
      void'(sq.pop_front());
      sq.push_back(bus.dom_rst_req_i);
    end
  endtask
  task automatic tick();
    bit [N-1:0] q;
    @(posedge clk);
    step();
    @(negedge clk);
    for (int i = 0; i < N; i++) q[i] = up[i] && (n - up_since[i] >= 1);
    chk("rst_n", 8'(bus.dom_rst_n_o), 8'(bus.test_mode ? {N{bus.test_rst_n}} : up));
    chk("qlfy", 8'(bus.dom_rdc_qlfy_o), 8'(q));
    chk("all_rel", 8'(bus.all_rel_o), 8'(&q));
  endtask
  function automatic logic [2:0] pu(int k);
    return {k >= 10, k >= 8, k >= 6};
  endfunction
  task automatic seq_check(string tag, bit sw);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk({tag, "_n"}, 8'(bus.dom_rst_n_o), 8'(pu(k)));
      chk({tag, "_all"}, 8'(bus.all_rel_o), 8'(k >= 11));
      if (sw) begin
        chk("sw_n", 8'(sbus.dom_rst_n_o), 8'(k >= 2));
        chk("sw_all", 8'(sbus.all_rel_o), 8'(k >= 3));
      end
    end
  endtask
  initial begin
    repeat (S) sq.push_back('1);
    bus.dom_rst_req_i = '0;
    bus.test_mode = 1'b0;
    bus.test_rst_n = 1'b0;
    sbus.dom_rst_req_i = '0;
    sbus.test_mode = 1'b0;
    sbus.test_rst_n = 1'b0;
    rst = 1'b1;
    repeat (5) tick();
    chk("reset_n", 8'(bus.dom_rst_n_o), 8'h0);
    chk("reset_q", 8'(bus.dom_rdc_qlfy_o), 8'h0);
    chk("reset_all", 8'(bus.all_rel_o), 8'h0);
    chk("reset_sw", 8'(sbus.dom_rst_n_o), 8'h0);
    rst = 1'b0;
    seq_check("pu", 1'b1);
    bus.dom_rst_req_i = 3'b010;
    sbus.dom_rst_req_i = 1'b1;
    for (int j = 0; j < 11; j++) begin
      tick();
      if (j == 0) begin
        bus.dom_rst_req_i = '0;
        sbus.dom_rst_req_i = 1'b0;
      end
      chk("mid_n", 8'(bus.dom_rst_n_o), 8'(j < 2 ? 3'b111 : j < 7 ? 3'b001 : j < 9 ? 3'b011 : 3'b111));
      chk("sw_pulse", 8'(sbus.dom_rst_n_o), 8'(!(j == 1 || j == 2)));
    end
    bus.dom_rst_req_i = 3'b001;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (j >= 2) chk("long_n", 8'(bus.dom_rst_n_o), 8'h0);
    end
    bus.dom_rst_req_i = '0;
    seq_check("long", 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("pre_rst_n", 8'(bus.dom_rst_n_o), 8'h1);
    rst = 1'b1;
    tick();
    chk("midrst_n", 8'(bus.dom_rst_n_o), 8'h0);
    chk("midrst_q", 8'(bus.dom_rdc_qlfy_o), 8'h0);
    rst = 1'b0;
    seq_check("re", 1'b1);
    bus.test_mode = 1'b1;
    bus.test_rst_n = 1'b0;
    #1;
    chk("dft0_n", 8'(bus.dom_rst_n_o), 8'h0);
    chk("dft0_q", 8'(bus.dom_rdc_qlfy_o), 8'h7);
    bus.test_rst_n = 1'b1;
    #1;
    chk("dft1_n", 8'(bus.dom_rst_n_o), 8'h7);
    bus.dom_rst_req_i = 3'b100;
    repeat (4) tick();
    chk("dft_req_q", 8'(bus.dom_rdc_qlfy_o), 8'h3);
    bus.dom_rst_req_i = '0;
    bus.test_rst_n = 1'b0;
    repeat (10) tick();
    bus.test_mode = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 11) == 0) bus.dom_rst_req_i = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 3) == 0) bus.dom_rst_req_i = '0;
      bus.test_mode = ($urandom_range(0, 19) == 0);
      bus.test_rst_n = 1'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
